// File: rtl/mest_pro_pkg.sv
// Shared types for the mest_pro core and its result buffer.
package mest_pro_pkg;

    localparam int unsigned RESULT_W = 8;

    typedef struct packed {
        logic                carry;
        logic                zero;
        logic [RESULT_W-1:0] result;
    } result_entry_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } buf_state_t;

endpackage

// File: rtl/mest_pro_sync_fifo.sv
// Generic first-word-fall-through FIFO with a registered head entry.
// A write into an empty FIFO becomes visible one cycle later (no bypass).
module mest_pro_sync_fifo #(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         wr_en,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic                         rd_en,
    output logic [DATA_W-1:0]            rd_data,
    output logic                         rd_valid,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full_c
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic [CNT_W-1:0]  count_n;
    logic [DATA_W-1:0] head_n;
    logic              rd_ok, wr_ok;

    assign full_c = (count == CNT_W'(DEPTH));
    assign rd_ok  = rd_en && rd_valid && !clear;
    assign wr_ok  = wr_en && (!full_c || rd_ok) && !clear;

    // Next pointers, occupancy and head entry after this cycle's update
    always_comb begin
        wr_ptr_n = wr_ptr;
        rd_ptr_n = rd_ptr;
        count_n  = count;
        head_n   = '0;
        if (clear) begin
            wr_ptr_n = '0;
            rd_ptr_n = '0;
            count_n  = '0;
        end else begin
            if (wr_ok) wr_ptr_n = PTR_W'(wr_ptr + PTR_W'(1));
            if (rd_ok) rd_ptr_n = PTR_W'(rd_ptr + PTR_W'(1));
            case ({wr_ok, rd_ok})
                2'b10:   count_n = CNT_W'(count + CNT_W'(1));
                2'b01:   count_n = CNT_W'(count - CNT_W'(1));
                default: count_n = count;
            endcase
            if (count_n != '0) begin
                head_n = (wr_ok && (wr_ptr == rd_ptr_n)) ? wr_data : mem[rd_ptr_n];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            wr_ptr   <= wr_ptr_n;
            rd_ptr   <= rd_ptr_n;
            count    <= count_n;
            rd_valid <= (count_n != '0);
            rd_data  <= head_n;
        end
    end

endmodule

// File: rtl/mest_pro_result_buffer.sv
// Buffers mest_pro result beats for a ready/valid consumer and reports
// when the core has finished and every buffered result has been drained.
module mest_pro_result_buffer
    import mest_pro_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = RESULT_W,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        i_reset,
    input  logic [DATA_WIDTH-1:0]       i_result,
    input  logic                        i_valid_result,
    input  logic                        i_carry,
    input  logic                        i_zero_flag,
    input  logic                        i_all_done,
    input  logic                        i_clear,
    output logic [DATA_WIDTH+1:0]       o_rd_data,
    output logic                        o_rd_valid,
    input  logic                        i_rd_ready,
    output logic [$clog2(DEPTH+1)-1:0]  o_count,
    output logic [CNT_WIDTH-1:0]        o_total,
    output logic                        o_overflow,
    output logic                        o_late_write,
    output logic                        o_drained
);

    localparam int unsigned ENTRY_W = DATA_WIDTH + 2;
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);

    buf_state_t          state, state_n;
    result_entry_t       wr_entry;
    logic [ENTRY_W-1:0]  wr_word;
    logic                full_c, rd_fire_c, wr_fire_c, run_c, empty_after_c;

    assign wr_entry.carry  = i_carry;
    assign wr_entry.zero   = i_zero_flag;
    assign wr_entry.result = RESULT_W'(i_result);
    assign wr_word         = ENTRY_W'(wr_entry);

    assign run_c         = (state == RUN);
    assign rd_fire_c     = o_rd_valid && i_rd_ready && !i_clear;
    assign wr_fire_c     = i_valid_result && run_c && (!full_c || rd_fire_c) && !i_clear;
    // Only used in FLUSH, where writes are refused
    assign empty_after_c = (o_count == '0) || ((o_count == CNT_W'(1)) && rd_fire_c);

    mest_pro_sync_fifo #(
        .DATA_W (ENTRY_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (i_reset),
        .clear    (i_clear),
        .wr_en    (wr_fire_c),
        .wr_data  (wr_word),
        .rd_en    (rd_fire_c),
        .rd_data  (o_rd_data),
        .rd_valid (o_rd_valid),
        .count    (o_count),
        .full_c   (full_c)
    );

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) state <= RUN;
        else         state <= state_n;
    end

    // Clear wins over all-done; all-done is ignored once the run has ended
    always_comb begin
        state_n = state;
        if (i_clear) begin
            state_n = RUN;
        end else begin
            case (state)
                RUN:     if (i_all_done)    state_n = FLUSH;
                FLUSH:   if (empty_after_c) state_n = DONE;
                DONE:    state_n = DONE;
                default: state_n = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            o_total      <= '0;
            o_overflow   <= 1'b0;
            o_late_write <= 1'b0;
            o_drained    <= 1'b0;
        end else if (i_clear) begin
            o_total      <= '0;
            o_overflow   <= 1'b0;
            o_late_write <= 1'b0;
            o_drained    <= 1'b0;
        end else begin
            if (wr_fire_c && (o_total != '1)) o_total <= CNT_WIDTH'(o_total + CNT_WIDTH'(1));
            if (i_valid_result && run_c && full_c && !rd_fire_c) o_overflow <= 1'b1;
            if (i_valid_result && !run_c) o_late_write <= 1'b1;
            o_drained <= (state == DONE);
        end
    end

endmodule

// File: tb/tb_mest_pro_result_buffer.sv
// Directed scoreboard bench for mest_pro_result_buffer.
module tb_mest_pro_result_buffer;

    logic        clk = 1'b0;
    logic        i_reset;
    logic [7:0]  i_result;
    logic        i_valid_result;
    logic        i_carry;
    logic        i_zero_flag;
    logic        i_all_done;
    logic        i_clear;
    logic [9:0]  o_rd_data;
    logic        o_rd_valid;
    logic        i_rd_ready;
    logic [4:0]  o_count;
    logic [15:0] o_total;
    logic        o_overflow;
    logic        o_late_write;
    logic        o_drained;

    int compared   = 0;
    int mismatched = 0;
    logic [9:0] sb[$];

    always #5 clk = ~clk;

    mest_pro_result_buffer #(
        .DATA_WIDTH (8),
        .DEPTH      (16),
        .CNT_WIDTH  (16)
    ) dut (
        .clk            (clk),
        .i_reset        (i_reset),
        .i_result       (i_result),
        .i_valid_result (i_valid_result),
        .i_carry        (i_carry),
        .i_zero_flag    (i_zero_flag),
        .i_all_done     (i_all_done),
        .i_clear        (i_clear),
        .o_rd_data      (o_rd_data),
        .o_rd_valid     (o_rd_valid),
        .i_rd_ready     (i_rd_ready),
        .o_count        (o_count),
        .o_total        (o_total),
        .o_overflow     (o_overflow),
        .o_late_write   (o_late_write),
        .o_drained      (o_drained)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock; if the consumer takes the head this cycle, score it first
    task automatic step();
        if (i_rd_ready && o_rd_valid) begin
            if (sb.size() == 0) check("rd_valid_unexpected", 32'(o_rd_valid), 32'd0);
            else                check("rd_data", 32'(o_rd_data), 32'(sb.pop_front()));
        end
        tick();
    endtask

    task automatic beat(input logic [7:0] r, input logic c, input logic z, input bit accept);
        i_result       = r;
        i_carry        = c;
        i_zero_flag    = z;
        i_valid_result = 1'b1;
        if (accept) sb.push_back({c, z, r});
        step();
        i_valid_result = 1'b0;
    endtask

    task automatic drain(input int budget);
        i_rd_ready = 1'b1;
        for (int n = 0; n < budget && (sb.size() != 0 || o_rd_valid); n++) step();
        check("drain_sb_left", 32'(sb.size()), 32'd0);
        check("drain_count", 32'(o_count), 32'd0);
    endtask

    task automatic pulse_clear();
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        i_reset = 1'b1;
        i_result = '0; i_valid_result = 1'b0; i_carry = 1'b0; i_zero_flag = 1'b0;
        i_all_done = 1'b0; i_clear = 1'b0; i_rd_ready = 1'b0;
        repeat (2) tick();
        check("rst_count", 32'(o_count), 32'd0);
        check("rst_total", 32'(o_total), 32'd0);
        check("rst_rd_valid", 32'(o_rd_valid), 32'd0);
        check("rst_rd_data", 32'(o_rd_data), 32'd0);
        check("rst_flags", 32'({o_overflow, o_late_write, o_drained}), 32'd0);
        i_reset = 1'b0;
        tick();

        // Three beats straight through
        i_rd_ready = 1'b1;
        beat(8'd5,   1'b0, 1'b0, 1'b1);
        beat(8'd0,   1'b0, 1'b1, 1'b1);
        beat(8'd255, 1'b1, 1'b0, 1'b1);
        drain(20);
        check("t1_total", 32'(o_total), 32'd3);
        check("t1_flags", 32'({o_overflow, o_late_write, o_drained}), 32'd0);

        // Overfill: 17th beat dropped
        pulse_clear();
        check("clr_total", 32'(o_total), 32'd0);
        i_rd_ready = 1'b0;
        for (int i = 0; i < 17; i++) beat(8'(i), 1'b0, 1'b0, i < 16);
        check("t2_count", 32'(o_count), 32'd16);
        check("t2_overflow", 32'(o_overflow), 32'd1);
        check("t2_total", 32'(o_total), 32'd16);
        drain(40);

        // Full FIFO with simultaneous read and write
        pulse_clear();
        i_rd_ready = 1'b0;
        for (int i = 0; i < 16; i++) beat(8'(8'h40 + i), 1'b0, 1'b0, 1'b1);
        check("t3_full_count", 32'(o_count), 32'd16);
        i_rd_ready = 1'b1;
        beat(8'hAA, 1'b1, 1'b1, 1'b1);
        check("t3_count", 32'(o_count), 32'd16);
        check("t3_overflow", 32'(o_overflow), 32'd0);
        check("t3_total", 32'(o_total), 32'd17);
        drain(40);

        // All-done, late write, drain to DONE
        pulse_clear();
        i_rd_ready = 1'b0;
        for (int i = 0; i < 4; i++) beat(8'(8'h10 + i), 1'(i), 1'b0, 1'b1);
        i_all_done = 1'b1;
        step();
        i_all_done = 1'b0;
        beat(8'h77, 1'b0, 1'b0, 1'b0);
        check("t4_late", 32'(o_late_write), 32'd1);
        check("t4_total", 32'(o_total), 32'd4);
        check("t4_count", 32'(o_count), 32'd4);
        check("t4_drained_early", 32'(o_drained), 32'd0);
        i_rd_ready = 1'b1;
        for (int n = 0; n < 32 && o_count != 0; n++) step();
        check("t4_sb_left", 32'(sb.size()), 32'd0);
        check("t4_count0", 32'(o_count), 32'd0);
        check("t4_drained_same", 32'(o_drained), 32'd0);
        tick();
        check("t4_drained", 32'(o_drained), 32'd1);
        beat(8'h99, 1'b0, 1'b0, 1'b0);
        check("t4_done_total", 32'(o_total), 32'd4);
        check("t4_done_rd_valid", 32'(o_rd_valid), 32'd0);

        // Clear in DONE beats a concurrent all-done
        i_all_done = 1'b1;
        pulse_clear();
        i_all_done = 1'b0;
        check("t5_count", 32'(o_count), 32'd0);
        check("t5_total", 32'(o_total), 32'd0);
        check("t5_flags", 32'({o_overflow, o_late_write, o_drained}), 32'd0);
        beat(8'h3C, 1'b0, 1'b1, 1'b1);
        check("t5_total_after", 32'(o_total), 32'd1);
        check("t5_late_after", 32'(o_late_write), 32'd0);
        drain(10);

        // Async reset mid-burst
        i_rd_ready = 1'b0;
        for (int i = 0; i < 5; i++) beat(8'(8'hC0 + i), 1'b0, 1'b0, 1'b1);
        check("t6_count", 32'(o_count), 32'd5);
        check("t6_total", 32'(o_total), 32'd6);
        #2;
        i_reset = 1'b1;
        #1;
        check("t6_async_count", 32'(o_count), 32'd0);
        check("t6_async_valid", 32'(o_rd_valid), 32'd0);
        check("t6_async_data", 32'(o_rd_data), 32'd0);
        check("t6_async_total", 32'(o_total), 32'd0);
        sb.delete();
        #3;
        i_reset = 1'b0;
        tick();
        check("t6_post_valid", 32'(o_rd_valid), 32'd0);
        check("t6_post_count", 32'(o_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
